npu_config_fifo: RTL and testbench
==================================

// Module: npu_config_fifo
// PURPOSE
//  Synchronous single-clock FIFO buffering 26-bit NPU configuration words between the
//  config-word producer and the NPU config decoder. Standard (non-FWFT) read mode:
//  dout updates one clock after an accepted read. Registered full/empty flags.
// PARAMETERS
//  DATA_W  26  word width (din/dout)
//  DEPTH   16  number of storage entries; power of two, >=2
//  ADDR_W  4   log2(DEPTH); pointer width
// PORTS
//  clk     in   1       clock; all logic on rising edge
//  srst    in   1       reset; synchronous, active-low
//  din     in   DATA_W  write data
//  wr_en   in   1       write request
//  rd_en   in   1       read request
//  dout    out  DATA_W  read data, registered
//  full    out  1       1 = DEPTH words stored
//  empty   out  1       1 = no words stored
//  data_count out ADDR_W+1  stored words (only with NPU_CONFIG_FIFO_DATA_COUNT_EN)
// BEHAVIOUR
//  - Reset (srst==0 at clk edge): wr/rd pointers=0, count=0, empty=1, full=0, dout=0.
//    Memory contents not cleared. Reset mid-operation discards all stored words.
//  - Write accepted iff wr_en && !full: mem[wr_ptr]<=din, wr_ptr++ (wraps mod DEPTH).
//  - Read accepted iff rd_en && !empty: dout<=mem[rd_ptr] on that edge, rd_ptr++ (wraps).
//    Read latency 1 cycle; dout holds last value when no read is accepted.
//  - Overflow: wr_en while full is ignored (data dropped, no state change).
//  - Underflow: rd_en while empty is ignored; dout unchanged.
//  - Simultaneous wr_en&&rd_en: not full and not empty -> both accepted, count unchanged;
//    empty -> only the write is accepted; full -> only the read is accepted.
//  - Flags derived from registered count, updated on the same edge as the access:
//    empty=(count==0), full=(count==DEPTH). Write-to-nonempty latency: empty falls on the
//    edge that accepts the first write; that word is readable on the next cycle.
//  - Ordering strictly first-in first-out; no word duplicated or skipped across wrap.
// CONFIGURATION
//  NPU_CONFIG_FIFO_DATA_COUNT_EN defined: adds output data_count[ADDR_W:0] = count,
//  reset 0, updated on the same edge as full/empty.
//  Undefined: no data_count port; all other behaviour identical.
// TESTING
//  1. Hold srst=0 5 cycles -> empty=1, full=0, dout=0; release, idle -> flags unchanged.
//  2. Write din=1..7 on consecutive cycles -> empty=0 after first write, full=0;
//     then rd_en=1 for 7 cycles -> dout=1,2,...,7 one cycle after each read; empty=1 after 7th.
//  3. Write DEPTH words (0x1..0x10), 17th write 0x3FFFFFF -> full=1, 17th dropped;
//     drain -> dout 0x1..0x10 in order, never 0x3FFFFFF.
//  4. rd_en=1 while empty for 3 cycles -> dout holds last value, empty stays 1.
//  5. Half-full, wr_en=rd_en=1 for 20 cycles (pointer wrap) -> count constant, FIFO order
//     intact; at full and at empty, simultaneous access per rules above.
//  6. Write 5 words, assert srst=0 one cycle -> empty=1, dout=0; next write/read returns
//     the new word only. With NPU_CONFIG_FIFO_DATA_COUNT_EN, data_count tracks all steps.

Source files
------------

// File: rtl/npu_config_fifo.sv
// ============================================================================
// Module  : npu_config_fifo
// Brief   : Single-clock FIFO for NPU configuration words, standard read mode
//           (dout registered, one cycle after an accepted read), registered
//           full/empty. Optional data_count port: NPU_CONFIG_FIFO_DATA_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module npu_config_fifo #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
`ifdef NPU_CONFIG_FIFO_DATA_COUNT_EN
  ,
  output logic [ADDR_W:0]   data_count
`endif
);

  localparam logic [ADDR_W:0] c_full_count = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty;
  logic              r_full;
  logic [DATA_W-1:0] r_dout;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W:0]   w_count_nxt;

  // Flags gate acceptance, so a write at full or read at empty is a no-op
  assign w_wr_acc = srst && wr_en && !r_full;
  assign w_rd_acc = srst && rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_dout   <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == c_full_count);
    end
  end

  // Storage has no reset; stale contents are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_dout;
  assign full  = r_full;
  assign empty = r_empty;
`ifdef NPU_CONFIG_FIFO_DATA_COUNT_EN
  assign data_count = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_npu_config_fifo.sv
// ============================================================================
// Module  : tb_npu_config_fifo
// Brief   : Self-checking bench for npu_config_fifo against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_npu_config_fifo;

  localparam int DATA_W = 26;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              srst;
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
`ifdef NPU_CONFIG_FIFO_DATA_COUNT_EN
  logic [ADDR_W:0]   data_count;
`endif

  npu_config_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .srst  (srst),
    .din   (din),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
`ifdef NPU_CONFIG_FIFO_DATA_COUNT_EN
    ,
    .data_count(data_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: contents as a queue, plus the last word handed out
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_dout = '0;

  typedef struct {
    bit                rst_n;
    bit                wr;
    bit                rd;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_dout;
    bit                exp_empty;
    bit                exp_full;
    int                exp_cnt;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic do_cycle(input bit rst_n, input bit wr, input bit rd, input logic [DATA_W-1:0] d);
    bit rd_ok;
    bit wr_ok;
    srst  = rst_n;
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_dout = '0;
    end else begin
      rd_ok = rd && (m_q.size() > 0);
      wr_ok = wr && (m_q.size() < DEPTH);
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_dout"},  32'(dout),  32'(m_dout));
    check({tag, "_empty"}, 32'(empty), 32'(m_q.size() == 0));
    check({tag, "_full"},  32'(full),  32'(m_q.size() == DEPTH));
`ifdef NPU_CONFIG_FIFO_DATA_COUNT_EN
    check({tag, "_count"}, 32'(data_count), 32'(m_q.size()));
`endif
  endtask

  initial begin
    srst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;

    // Reset hold, idle, seven writes, seven reads, three underflow reads
    for (int i = 0; i < 5; i++) vecs[i] = '{0, 0, 0, 0, 0, 1, 0, 0};
    vecs[5] = '{1, 0, 0, 0, 0, 1, 0, 0};
    vecs[6] = '{1, 0, 0, 0, 0, 1, 0, 0};
    for (int k = 1; k <= 7; k++) vecs[6+k] = '{1, 1, 0, 26'(k), 0, 0, 0, k};
    for (int k = 1; k <= 7; k++) vecs[13+k] = '{1, 0, 1, 0, 26'(k), (k == 7), 0, 7-k};
    for (int i = 21; i < 24; i++) vecs[i] = '{1, 0, 1, 0, 7, 1, 0, 0};

    for (int i = 0; i < 24; i++) begin
      do_cycle(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].d);
      check($sformatf("vec%0d_dout", i),  32'(dout),  32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_full", i),  32'(full),  32'(vecs[i].exp_full));
`ifdef NPU_CONFIG_FIFO_DATA_COUNT_EN
      check($sformatf("vec%0d_count", i), 32'(data_count), 32'(vecs[i].exp_cnt));
`endif
    end

    // Fill to DEPTH, overflow write must be dropped, then drain in order
    for (int k = 1; k <= DEPTH; k++) begin
      do_cycle(1, 1, 0, 26'(k));
      check("fill_full", 32'(full), 32'(k == DEPTH));
    end
    do_cycle(1, 1, 0, 26'h3FFFFFF);
    check("ovf_full", 32'(full), 32'd1);
    check_model("ovf");
    for (int k = 1; k <= DEPTH; k++) begin
      do_cycle(1, 0, 1, 0);
      check("drain_dout", 32'(dout), 32'(k));
    end
    check("drain_empty", 32'(empty), 32'd1);
    do_cycle(1, 0, 1, 0);
    check("drain_nodup", 32'(dout), 32'(DEPTH));

    // Half full, then sustained simultaneous access across pointer wrap
    for (int k = 0; k < DEPTH/2; k++) do_cycle(1, 1, 0, 26'(16'hA00 + k));
    for (int k = 0; k < 20; k++) begin
      do_cycle(1, 1, 1, 26'(16'hB00 + k));
      check_model("wrap");
      check("wrap_level", 32'(empty | full), 32'd0);
    end
    // Top up to full, then simultaneous access: read only
    while (m_q.size() < DEPTH) do_cycle(1, 1, 0, 26'($urandom));
    check("top_full", 32'(full), 32'd1);
    do_cycle(1, 1, 1, 26'h123);
    check_model("simul_full");
    check("simul_full_flag", 32'(full), 32'd0);
    while (m_q.size() > 0) begin
      do_cycle(1, 0, 1, 0);
      check_model("drain2");
    end
    // Empty, simultaneous access: write only, dout holds
    do_cycle(1, 1, 1, 26'h2BEEF);
    check_model("simul_empty");
    check("simul_empty_flag", 32'(empty), 32'd0);
    do_cycle(1, 0, 1, 0);
    check("simul_empty_rd", 32'(dout), 32'h2BEEF);

    // Reset mid-operation discards everything
    for (int k = 0; k < 5; k++) do_cycle(1, 1, 0, 26'(16'hC00 + k));
    do_cycle(0, 0, 0, 0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout",  32'(dout),  32'd0);
    check_model("rst");
    do_cycle(1, 1, 0, 26'hABC);
    check("post_rst_dout0", 32'(dout), 32'd0);
    do_cycle(1, 0, 1, 0);
    check("post_rst_rd", 32'(dout), 32'hABC);
    check("post_rst_empty", 32'(empty), 32'd1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 99) < 55),
               ($urandom_range(0, 99) < 45), 26'($urandom));
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
